alu_packet_engine: RTL and testbench
====================================

# alu_packet_engine

Packet-level responder for the UART ALU. It sits between the byte-stream output of the UART receiver and the byte-stream input of the UART transmitter. It parses each request packet (opcode, reserved byte, 16-bit length), executes the opcode, and streams the response bytes back. Supported opcodes are echo (payload returned verbatim) and add (sum of 32-bit little-endian operands, returned as 4 bytes).

## Interface
Parameters:
- OPC_ADD, 8'h01, opcode for 32-bit add.
- OPC_ECHO, 8'hEC, opcode for echo.

Ports:
- clk_i, input, 1, single clock; all state on rising edge.
- reset_i, input, 1, asynchronous active-high reset.
- s_axis_tdata, input, 8, request byte from UART receiver.
- s_axis_tvalid, input, 1, request byte valid.
- s_axis_tready, output, 1, engine accepts the byte this cycle.
- m_axis_tdata, output, 8, response byte to UART transmitter.
- m_axis_tvalid, output, 1, response byte valid.
- m_axis_tready, input, 1, transmitter accepts the byte.
- busy_o, output, 1, high whenever state is not OPCODE.
- err_o, output, 1, one-cycle pulse on unknown opcode or add length not a multiple of 4.

## Operation
- Packet format: byte0 opcode, byte1 reserved (ignored), byte2 length LSB, byte3 length MSB, then payload.
  - Length counts the whole packet, including the 4 header bytes.
  - Payload count = length − 4.
  - If length < 4, payload count = 0.
- States:
  - OPCODE → RSVD → LEN_LO → LEN_HI → PAYLOAD, or → RESULT (add with 0 payload), or → OPCODE (echo/unknown with 0 payload).
  - PAYLOAD → RESULT (add) or → OPCODE (echo/unknown) after the last payload byte is accepted.
  - RESULT → OPCODE after the 4th result byte is accepted.
- Header states: s_axis_tready = 1. Opcode and length are captured on handshake.
- Payload counter: 16-bit down-counter `rem`, loaded at LEN_HI. Decrements on each accepted payload byte. The last payload byte is the one accepted with rem == 1.
- ADD:
  - s_axis_tready = 1 in PAYLOAD.
  - Bytes shift into a 32-bit operand register, LSB first.
  - On every 4th byte, accumulate acc = (acc + operand) mod 2^32.
  - acc clears at the OPCODE handshake.
  - Zero operands → result 32'h0000_0000.
  - Trailing 1–3 bytes (payload count not a multiple of 4) are consumed and discarded. err_o pulses on the last payload byte.
- RESULT: emits acc[7:0], [15:8], [23:16], [31:24] in that order, one byte per m_axis handshake. s_axis_tready = 0 throughout.
- ECHO:
  - In PAYLOAD, s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - Each accepted byte loads the output register.
  - Returning to OPCODE does not wait for the final echoed byte to drain. The next header may be accepted while it is still pending.
  - In OPCODE with m_axis_tvalid still high from echo, header bytes are still accepted. No header opcode produces output before RESULT/PAYLOAD.
- Unknown opcode: err_o pulses at the opcode handshake. Payload is consumed with s_axis_tready = 1. No response.
- Output register rules:
  - m_axis_tvalid, once high, holds and m_axis_tdata is stable until m_axis_tready.
  - Never overwritten before the handshake.

## Timing
- Reset values: s_axis_tready = 1 (OPCODE state), m_axis_tvalid = 0, m_axis_tdata = 0, busy_o = 0, err_o = 0, acc = 0, rem = 0.
- Reset mid-packet: the partial packet is dropped. The next byte after release is treated as an opcode.
- Throughput: header and add-payload accept 1 byte/cycle.
- Add latency: m_axis_tvalid rises the cycle after the last payload byte is accepted (or after the LEN_HI handshake when payload = 0).
  - The final operand is included in the result: accumulation uses the completed operand combinationally.
- Echo latency: m_axis_tvalid rises the cycle after the byte is accepted. With m_axis_tready held at 1, echo sustains 1 byte/cycle.
- Simultaneous accept and drain in echo: the new byte replaces the drained byte in the same edge; m_axis_tvalid stays 1.
- Length 16'hFFFF: rem = 65531; no overflow. Length 0–4: no payload.

## Test plan
- Add two operands:
  - Stimulus: 01 00 0C 00 | 05 00 00 00 | 07 00 00 00, m_axis_tready = 1.
  - Response: bytes 0C 00 00 00. err_o never pulses. busy_o low after the 4th byte.
- Add wraparound:
  - Stimulus: operands FFFFFFFF and 00000002 (length 0x000C).
  - Response: 01 00 00 00.
  - Also cover 50 random operands (length 4 + 200 = 0x00CC) and compare against a modulo-2^32 reference sum.
- Echo with backpressure:
  - Stimulus: EC 00 08 00 | DE AD BE EF, with m_axis_tready toggling 1/0 every cycle.
  - Response: DE AD BE EF in order, with no byte dropped or duplicated.
- Boundary lengths:
  - Add with length 4 → response 00 00 00 00.
  - Echo with length 4 → no output; next packet parses correctly.
  - Add with length 6 (payload AA BB) → err_o pulse, response 00 00 00 00.
- Unknown opcode:
  - Stimulus: 7F 00 06 00 11 22, then a valid add packet.
  - Response: err_o pulses once, no response bytes for the unknown packet, correct add result afterwards.
- Reset mid-packet:
  - Stimulus: assert reset_i after 01 00 0C 00 05; release; send a full add packet 3 + 4.
  - Response: only 07 00 00 00 is emitted. All outputs are at reset values while reset_i is high.

Source files
------------

// File: rtl/alu_packet_engine.sv
// Packet responder for the UART ALU: parses opcode/reserved/length headers,
// echoes payloads or sums 32-bit little-endian operands, and streams responses.
module alu_packet_engine #(
  parameter logic [7:0] OPC_ADD  = 8'h01,
  parameter logic [7:0] OPC_ECHO = 8'hEC
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       busy_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    ST_OPCODE,
    ST_RSVD,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_PAYLOAD,
    ST_RESULT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] operand_q, operand_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic [2:0]  res_cnt_q, res_cnt_d;
  logic        err_q, err_d;

  logic        s_hs, m_hs, is_add, is_echo, last_pay;
  logic [15:0] len_full, pay_len;
  logic [31:0] operand_next;

  assign s_hs         = s_axis_tvalid && s_axis_tready;
  assign m_hs         = out_valid_q && m_axis_tready;
  assign is_add       = (opcode_q == OPC_ADD);
  assign is_echo      = (opcode_q == OPC_ECHO);
  assign len_full     = {s_axis_tdata, len_lo_q};
  assign pay_len      = (len_full < 16'd4) ? 16'd0 : (len_full - 16'd4);
  assign last_pay     = (state_q == ST_PAYLOAD) && s_hs && (rem_q == 16'd1);
  assign operand_next = {s_axis_tdata, operand_q[31:8]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_OPCODE;
      opcode_q    <= 8'd0;
      len_lo_q    <= 8'd0;
      rem_q       <= 16'd0;
      operand_q   <= 32'd0;
      byte_cnt_q  <= 2'd0;
      acc_q       <= 32'd0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      res_cnt_q   <= 3'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      len_lo_q    <= len_lo_d;
      rem_q       <= rem_d;
      operand_q   <= operand_d;
      byte_cnt_q  <= byte_cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      res_cnt_q   <= res_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OPCODE:  if (s_hs) state_d = ST_RSVD;
      ST_RSVD:    if (s_hs) state_d = ST_LEN_LO;
      ST_LEN_LO:  if (s_hs) state_d = ST_LEN_HI;
      ST_LEN_HI: begin
        if (s_hs) begin
          if (pay_len != 16'd0) state_d = ST_PAYLOAD;
          else if (is_add)      state_d = ST_RESULT;
          else                  state_d = ST_OPCODE;
        end
      end
      ST_PAYLOAD: if (last_pay) state_d = is_add ? ST_RESULT : ST_OPCODE;
      ST_RESULT:  if (m_hs && res_cnt_q[2]) state_d = ST_OPCODE;
      default:    state_d = ST_OPCODE;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b1;
    case (state_q)
      ST_PAYLOAD: s_axis_tready = is_echo ? (!out_valid_q || m_axis_tready) : 1'b1;
      ST_RESULT:  s_axis_tready = 1'b0;
      default:    s_axis_tready = 1'b1;
    endcase
    busy_o        = (state_q != ST_OPCODE);
    m_axis_tdata  = out_data_q;
    m_axis_tvalid = out_valid_q;
    err_o         = err_q;
  end

  always_comb begin
    opcode_d    = opcode_q;
    len_lo_d    = len_lo_q;
    rem_d       = rem_q;
    operand_d   = operand_q;
    byte_cnt_d  = byte_cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !m_axis_tready;
    res_cnt_d   = res_cnt_q;
    err_d       = 1'b0;
    case (state_q)
      ST_OPCODE: begin
        if (s_hs) begin
          opcode_d   = s_axis_tdata;
          acc_d      = 32'd0;
          operand_d  = 32'd0;
          byte_cnt_d = 2'd0;
          err_d      = (s_axis_tdata != OPC_ADD) && (s_axis_tdata != OPC_ECHO);
        end
      end
      ST_LEN_LO: if (s_hs) len_lo_d = s_axis_tdata;
      ST_LEN_HI: if (s_hs) rem_d = pay_len;
      ST_PAYLOAD: begin
        if (s_hs) begin
          rem_d = rem_q - 16'd1;
          if (is_add) begin
            operand_d  = operand_next;
            byte_cnt_d = byte_cnt_q + 2'd1;
            // completed operand is summed combinationally so the last one lands in this edge
            if (byte_cnt_q == 2'd3) acc_d = acc_q + operand_next;
            if (last_pay && (byte_cnt_q != 2'd3)) err_d = 1'b1;
          end
          if (is_echo) begin
            out_data_d  = s_axis_tdata;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_RESULT: begin
        if ((!out_valid_q || m_hs) && !res_cnt_q[2]) begin
          out_data_d  = acc_q[{res_cnt_q[1:0], 3'b000} +: 8];
          out_valid_d = 1'b1;
          res_cnt_d   = res_cnt_q + 3'd1;
        end
      end
      default: ;
    endcase
    // preload the first result byte on entry, unless an echo byte is still waiting
    if ((state_d == ST_RESULT) && (state_q != ST_RESULT)) begin
      res_cnt_d = 3'd0;
      if (!out_valid_q || m_hs) begin
        out_data_d  = acc_d[7:0];
        out_valid_d = 1'b1;
        res_cnt_d   = 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_packet_engine.sv
// Directed bench for alu_packet_engine: add, echo, boundary lengths,
// unknown opcode and mid-packet reset, checked against hand-computed bytes.
module tb_alu_packet_engine;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] s_axis_tdata = 8'd0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       busy_o;
  logic       err_o;

  int n_checks = 0;
  int n_errors = 0;
  int err_cnt  = 0;
  bit tog      = 1'b0;

  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pl_q[$];

  alu_packet_engine dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    #1;
    if (tog) m_axis_tready = ~m_axis_tready;
    else     m_axis_tready = 1'b1;
  end

  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (m_axis_tvalid && m_axis_tready) out_q.push_back(m_axis_tdata);
      if (err_o) err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit ok;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 2000) begin
      @(negedge clk_i);
      ok = s_axis_tready;
      @(posedge clk_i);
      #1;
      n++;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [15:0] len);
    send_byte(op);
    send_byte(8'h00);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    foreach (pl_q[i]) send_byte(pl_q[i]);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    pl_q.push_back(w[7:0]);
    pl_q.push_back(w[15:8]);
    pl_q.push_back(w[23:16]);
    pl_q.push_back(w[31:24]);
  endtask

  task automatic exp_word(input logic [31:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[31:24]);
  endtask

  task automatic expect_resp(input string tag);
    int n;
    n = 0;
    while (out_q.size() < exp_q.size() && n < 1000) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    repeat (8) @(posedge clk_i);
    #1;
    check({tag, "_count"}, out_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < out_q.size()) check($sformatf("%s_b%0d", tag, i), {24'd0, out_q[i]}, {24'd0, exp_q[i]});
    end
    out_q.delete();
    exp_q.delete();
    pl_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk_i);
    check({tag, "_s_tready"}, {31'd0, s_axis_tready}, 32'd1);
    check({tag, "_m_tvalid"}, {31'd0, m_axis_tvalid}, 32'd0);
    check({tag, "_m_tdata"},  {24'd0, m_axis_tdata},  32'd0);
    check({tag, "_busy"},     {31'd0, busy_o},        32'd0);
    check({tag, "_err"},      {31'd0, err_o},         32'd0);
  endtask

  initial begin
    int e0;
    logic [31:0] sum, r;

    repeat (3) @(posedge clk_i);
    check_reset_vals("rst");
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // 5 + 7, also checks one-cycle result latency
    e0 = err_cnt;
    push_word(32'd5);
    push_word(32'd7);
    send_pkt(8'h01, 16'h000C);
    check("add_latency_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    exp_word(32'h0000_000C);
    expect_resp("add_5_7");
    check("add_5_7_err", err_cnt - e0, 32'd0);
    check("add_5_7_busy", {31'd0, busy_o}, 32'd0);

    push_word(32'hFFFF_FFFF);
    push_word(32'h0000_0002);
    send_pkt(8'h01, 16'h000C);
    exp_word(32'h0000_0001);
    expect_resp("add_wrap");

    sum = 32'd0;
    for (int i = 0; i < 50; i++) begin
      r = $urandom;
      sum = sum + r;
      push_word(r);
    end
    send_pkt(8'h01, 16'h00CC);
    exp_word(sum);
    expect_resp("add_rand50");

    tog = 1'b1;
    pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_pkt(8'hEC, 16'h0008);
    exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    expect_resp("echo_bp");
    tog = 1'b0;

    e0 = err_cnt;
    send_pkt(8'h01, 16'h0004);
    exp_word(32'h0000_0000);
    expect_resp("add_len4");
    check("add_len4_err", err_cnt - e0, 32'd0);

    send_pkt(8'hEC, 16'h0004);
    expect_resp("echo_len4");
    push_word(32'd1);
    push_word(32'd2);
    send_pkt(8'h01, 16'h000C);
    exp_word(32'h0000_0003);
    expect_resp("after_echo_len4");

    e0 = err_cnt;
    pl_q = '{8'hAA, 8'hBB};
    send_pkt(8'h01, 16'h0006);
    exp_word(32'h0000_0000);
    expect_resp("add_len6");
    check("add_len6_err", err_cnt - e0, 32'd1);

    e0 = err_cnt;
    pl_q = '{8'h11, 8'h22};
    send_pkt(8'h7F, 16'h0006);
    expect_resp("unknown");
    check("unknown_err", err_cnt - e0, 32'd1);
    push_word(32'd3);
    push_word(32'd4);
    send_pkt(8'h01, 16'h000C);
    exp_word(32'h0000_0007);
    expect_resp("after_unknown");

    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h0C);
    send_byte(8'h00);
    send_byte(8'h05);
    s_axis_tvalid = 1'b0;
    check("mid_busy_before_rst", {31'd0, busy_o}, 32'd1);
    reset_i = 1'b1;
    check_reset_vals("mid_rst");
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    out_q.delete();
    @(posedge clk_i);
    #1;
    push_word(32'd3);
    push_word(32'd4);
    send_pkt(8'h01, 16'h000C);
    exp_word(32'h0000_0007);
    expect_resp("after_mid_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
